// File: rtl/fpu_cmp_ctrl_pkg.sv
// Opcode encoding and unit-selection helpers shared by the FPU compare sequencer files.
package fpu_cmp_ctrl_pkg;

   typedef enum logic [1:0] {
      FCMP_FEQ = 2'b00,
      FCMP_FLT = 2'b01,
      FCMP_FLE = 2'b10,
      FCMP_RSV = 2'b11
   } fcmp_op_e;

   function automatic logic uses_feq(input fcmp_op_e op);
      return (op == FCMP_FEQ) || (op == FCMP_FLE);
   endfunction

   function automatic logic uses_flt(input fcmp_op_e op);
      return (op == FCMP_FLT) || (op == FCMP_FLE);
   endfunction

endpackage

// File: rtl/fpu_cmp_fifo.sv
// In-order result FIFO for the compare sequencer: DEPTH entries of W bits with an occupancy count.
module fpu_cmp_fifo
   import fpu_cmp_ctrl_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned W     = 7,
   parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          clr,
   input  logic          push,
   input  logic [W-1:0]  din,
   input  logic          pop,
   output logic [W-1:0]  dout,
   output logic [CW-1:0] count
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          do_pop;

   assign do_pop = pop && (count != '0);
   assign dout   = mem[rd_ptr];

   // Explicit wrap keeps non-power-of-two depths correct.
   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= next_ptr(wr_ptr);
         end
         if (do_pop) rd_ptr <= next_ptr(rd_ptr);
         if (push && !do_pop)      count <= count + CW'(1);
         else if (!push && do_pop) count <= count - CW'(1);
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
      !(push && !clr && !do_pop && (count == CW'(DEPTH))));

endmodule

// File: rtl/fpu_cmp_ctrl.sv
// Sequencer for the feq/flt compare units: issue, in-flight tracking, in-order results.
// Optional synchronous flush port when FPU_CMP_FLUSH_EN is defined.
module fpu_cmp_ctrl
   import fpu_cmp_ctrl_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned TAG_W = 6,
   parameter int unsigned LAT   = 1
) (
   input  logic             clk,
   input  logic             rstn,
`ifdef FPU_CMP_FLUSH_EN
   input  logic             flush,
`endif
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [1:0]       req_op,
   input  logic [31:0]      req_a,
   input  logic [31:0]      req_b,
   input  logic [TAG_W-1:0] req_tag,
   output logic [31:0]      cmp_a,
   output logic [31:0]      cmp_b,
   output logic             feq_en,
   output logic             flt_en,
   input  logic [31:0]      feq_c,
   input  logic             feq_ready,
   input  logic [31:0]      flt_c,
   input  logic             flt_ready,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [31:0]      res_data,
   output logic [TAG_W-1:0] res_tag,
   output logic             err
);

   localparam int unsigned PD = LAT + 1;
   localparam int unsigned X  = LAT;
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned UW = $clog2(DEPTH + PD + 1);

   logic flush_i;
`ifdef FPU_CMP_FLUSH_EN
   assign flush_i = flush;
`else
   assign flush_i = 1'b0;
`endif

   logic [PD-1:0]    p_v;
   logic [PD-1:0]    p_k;
   fcmp_op_e         p_op  [PD];
   logic [TAG_W-1:0] p_tag [PD];

   logic [CW-1:0]    fifo_count;
   logic [TAG_W:0]   fifo_dout;
   logic [UW-1:0]    used;
   logic             accept;
   fcmp_op_e         req_op_e;
   fcmp_op_e         x_op;
   logic             live, ghost;
   logic             exp_feq, exp_flt, ign_feq, ign_flt;
   logic             push, push_bit, err_set;
   logic             unused_hi;

   assign unused_hi = ^{feq_c[31:1], flt_c[31:1]};
   assign req_op_e  = fcmp_op_e'(req_op);

   always_comb begin
      used = UW'(fifo_count);
      for (int unsigned i = 0; i < PD; i++) used = used + UW'(p_v[i]);
   end

   assign req_ready = (used < UW'(DEPTH)) && !flush_i;
   assign accept    = req_valid && req_ready;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cmp_a  <= '0;
         cmp_b  <= '0;
         feq_en <= 1'b0;
         flt_en <= 1'b0;
      end else begin
         if (accept) begin
            cmp_a <= req_a;
            cmp_b <= req_b;
         end
         feq_en <= accept && uses_feq(req_op_e);
         flt_en <= accept && uses_flt(req_op_e);
      end
   end

   // p_k follows flushed ops whose enables already fired so their late readies are not errors.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         p_v <= '0;
         p_k <= '0;
         for (int unsigned i = 0; i < PD; i++) begin
            p_op[i]  <= FCMP_FEQ;
            p_tag[i] <= '0;
         end
      end else begin
         p_v[0]   <= accept;
         p_k[0]   <= 1'b0;
         p_op[0]  <= req_op_e;
         p_tag[0] <= req_tag;
         for (int unsigned i = 1; i < PD; i++) begin
            p_v[i]   <= p_v[i-1] && !flush_i;
            p_k[i]   <= p_k[i-1] || (p_v[i-1] && flush_i);
            p_op[i]  <= p_op[i-1];
            p_tag[i] <= p_tag[i-1];
         end
      end
   end

   assign x_op    = p_op[X];
   assign live    = p_v[X] && !flush_i;
   assign ghost   = p_k[X] || (p_v[X] && flush_i);
   assign exp_feq = live && uses_feq(x_op);
   assign exp_flt = live && uses_flt(x_op);
   assign ign_feq = ghost && uses_feq(x_op);
   assign ign_flt = ghost && uses_flt(x_op);
   assign push    = live;

   always_comb begin
      push_bit = 1'b0;
      case (x_op)
         FCMP_FEQ: push_bit = feq_c[0];
         FCMP_FLT: push_bit = flt_c[0];
         FCMP_FLE: push_bit = feq_c[0] | flt_c[0];
         default:  push_bit = 1'b0;
      endcase
   end

   assign err_set = (live && (x_op == FCMP_RSV))
                 || (exp_feq && !feq_ready)
                 || (exp_flt && !flt_ready)
                 || (feq_ready && !exp_feq && !ign_feq)
                 || (flt_ready && !exp_flt && !ign_flt);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) err <= 1'b0;
      else       err <= err | err_set;
   end

   fpu_cmp_fifo #(
      .DEPTH (DEPTH),
      .W     (TAG_W + 1),
      .CW    (CW)
   ) u_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .clr   (flush_i),
      .push  (push),
      .din   ({push_bit, p_tag[X]}),
      .pop   (res_ready),
      .dout  (fifo_dout),
      .count (fifo_count)
   );

   assign res_valid = (fifo_count != '0);
   assign res_data  = {31'b0, fifo_dout[TAG_W]};
   assign res_tag   = fifo_dout[TAG_W-1:0];

endmodule

// File: tb/tb_fpu_cmp_ctrl.sv
// Directed self-checking bench for fpu_cmp_ctrl with behavioural latency-1 feq/flt units.
module tb_fpu_cmp_ctrl;

   logic        clk;
   logic        rstn;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_op;
   logic [31:0] req_a, req_b;
   logic [5:0]  req_tag;
   logic [31:0] cmp_a, cmp_b;
   logic        feq_en, flt_en;
   logic [31:0] feq_c, flt_c;
   logic        feq_ready, flt_ready;
   logic        unit_feq_rdy, unit_flt_rdy;
   logic        force_feq;
   logic        res_valid, res_ready;
   logic [31:0] res_data;
   logic [5:0]  res_tag;
   logic        err;
`ifdef FPU_CMP_FLUSH_EN
   logic        flush;
`endif

   int checks = 0;
   int errors = 0;

   fpu_cmp_ctrl #(.DEPTH(4), .TAG_W(6), .LAT(1)) dut (
      .clk       (clk),
      .rstn      (rstn),
`ifdef FPU_CMP_FLUSH_EN
      .flush     (flush),
`endif
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_tag   (req_tag),
      .cmp_a     (cmp_a),
      .cmp_b     (cmp_b),
      .feq_en    (feq_en),
      .flt_en    (flt_en),
      .feq_c     (feq_c),
      .feq_ready (feq_ready),
      .flt_c     (flt_c),
      .flt_ready (flt_ready),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .res_tag   (res_tag),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic is_nan(input logic [31:0] x);
      return (x[30:23] == 8'hFF) && (x[22:0] != 0);
   endfunction

   function automatic logic f_eq(input logic [31:0] a, input logic [31:0] b);
      if (is_nan(a) || is_nan(b)) return 1'b0;
      return (a == b) || (((a | b) & 32'h7FFF_FFFF) == 0);
   endfunction

   function automatic logic f_lt(input logic [31:0] a, input logic [31:0] b);
      if (is_nan(a) || is_nan(b)) return 1'b0;
      if (((a | b) & 32'h7FFF_FFFF) == 0) return 1'b0;
      if (a[31] != b[31]) return a[31];
      if (!a[31]) return a[30:0] < b[30:0];
      return a[30:0] > b[30:0];
   endfunction

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         unit_feq_rdy <= 1'b0;
         unit_flt_rdy <= 1'b0;
         feq_c        <= '0;
         flt_c        <= '0;
      end else begin
         unit_feq_rdy <= feq_en;
         unit_flt_rdy <= flt_en;
         feq_c        <= {31'b0, f_eq(cmp_a, cmp_b)};
         flt_c        <= {31'b0, f_lt(cmp_a, cmp_b)};
      end
   end

   assign feq_ready = unit_feq_rdy | force_feq;
   assign flt_ready = unit_flt_rdy;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [5:0] tag);
      req_valid = 1'b1;
      req_op    = op;
      req_a     = a;
      req_b     = b;
      req_tag   = tag;
   endtask

   task automatic pulse_reset();
      rstn = 1'b0;
      #2;
      rstn = 1'b1;
      step();
   endtask

   task automatic test_reset();
      #1;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got %b exp 0", res_valid); end
      checks++; if ({feq_en, flt_en, err} !== 3'b000) begin errors++; $display("FAIL reset_en_err got %b exp 000", {feq_en, flt_en, err}); end
      checks++; if ({cmp_a, cmp_b} !== 64'h0) begin errors++; $display("FAIL reset_cmp got %h exp 0", {cmp_a, cmp_b}); end
      checks++; if ({res_data, res_tag} !== 38'h0) begin errors++; $display("FAIL reset_res got %h exp 0", {res_data, res_tag}); end
      #6 rstn = 1'b1;
      step();
   endtask

   task automatic test_feq();
      drive(2'b00, 32'h0000_0000, 32'h8000_0000, 6'd5);
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL feq_req_ready got %b exp 1", req_ready); end
      step();
      req_valid = 1'b0;
      checks++; if ({feq_en, flt_en} !== 2'b10) begin errors++; $display("FAIL feq_enables got %b exp 10", {feq_en, flt_en}); end
      checks++; if ({cmp_a, cmp_b} !== {32'h0, 32'h8000_0000}) begin errors++; $display("FAIL feq_operands got %h exp 0000000080000000", {cmp_a, cmp_b}); end
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL feq_early_valid got %b exp 0", res_valid); end
      step();
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL feq_valid_e1 got %b exp 0", res_valid); end
      checks++; if (feq_en !== 1'b0) begin errors++; $display("FAIL feq_en_drop got %b exp 0", feq_en); end
      step();
      checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL feq_valid_e2 got %b exp 1", res_valid); end
      checks++; if ({res_data, res_tag} !== {32'd1, 6'd5}) begin errors++; $display("FAIL feq_result got %h/%0d exp 1/5", res_data, res_tag); end
      step();
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL feq_popped got %b exp 0", res_valid); end
   endtask

   task automatic test_back_to_back_flt();
      drive(2'b01, 32'h3F80_0000, 32'h4000_0000, 6'd7);
      step();
      drive(2'b01, 32'h4000_0000, 32'h3F80_0000, 6'd8);
      step();
      req_valid = 1'b0;
      checks++; if ({feq_en, flt_en} !== 2'b01) begin errors++; $display("FAIL flt_enables got %b exp 01", {feq_en, flt_en}); end
      step();
      checks++; if ({res_valid, res_data[0], res_tag} !== {1'b1, 1'b1, 6'd7}) begin errors++; $display("FAIL flt_first got v%b d%b t%0d exp v1 d1 t7", res_valid, res_data[0], res_tag); end
      step();
      checks++; if ({res_valid, res_data, res_tag} !== {1'b1, 32'd0, 6'd8}) begin errors++; $display("FAIL flt_second got v%b d%h t%0d exp v1 d0 t8", res_valid, res_data, res_tag); end
      step();
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL flt_drained got %b exp 0", res_valid); end
   endtask

   task automatic test_fle();
      drive(2'b10, 32'h4000_0000, 32'h4000_0000, 6'd9);
      step();
      drive(2'b10, 32'h4040_0000, 32'h4000_0000, 6'd10);
      checks++; if ({feq_en, flt_en} !== 2'b11) begin errors++; $display("FAIL fle_enables got %b exp 11", {feq_en, flt_en}); end
      step();
      req_valid = 1'b0;
      step();
      checks++; if ({res_valid, res_data, res_tag} !== {1'b1, 32'd1, 6'd9}) begin errors++; $display("FAIL fle_equal got v%b d%h t%0d exp v1 d1 t9", res_valid, res_data, res_tag); end
      step();
      checks++; if ({res_valid, res_data, res_tag} !== {1'b1, 32'd0, 6'd10}) begin errors++; $display("FAIL fle_greater got v%b d%h t%0d exp v1 d0 t10", res_valid, res_data, res_tag); end
      step();
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL fle_no_err got %b exp 0", err); end
   endtask

   task automatic test_credits();
      int accepted = 0;
      int exp_tag  = 1;
      logic will_accept, will_pop;
      res_ready = 1'b0;
      drive(2'b00, 32'h3F80_0000, 32'h3F80_0000, 6'd1);
      for (int c = 0; c < 10; c++) begin
         will_accept = req_valid && req_ready;
         step();
         if (will_accept) begin
            accepted++;
            req_tag = 6'(accepted + 1);
         end
      end
      checks++; if (accepted !== 4) begin errors++; $display("FAIL credit_accepts got %0d exp 4", accepted); end
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL credit_stall got %b exp 0", req_ready); end
      checks++; if ({res_valid, res_tag} !== {1'b1, 6'd1}) begin errors++; $display("FAIL credit_head got v%b t%0d exp v1 t1", res_valid, res_tag); end
      res_ready = 1'b1;
      for (int c = 0; c < 40 && exp_tag <= 6; c++) begin
         will_accept = req_valid && req_ready;
         will_pop    = res_valid;
         if (will_pop) begin
            checks++; if ({res_data, res_tag} !== {32'd1, 6'(exp_tag)}) begin errors++; $display("FAIL credit_order got d%h t%0d exp d1 t%0d", res_data, res_tag, exp_tag); end
         end
         step();
         if (will_pop) exp_tag++;
         if (will_accept) begin
            accepted++;
            req_tag = 6'(accepted + 1);
            if (accepted == 6) req_valid = 1'b0;
         end
      end
      checks++; if (exp_tag !== 7) begin errors++; $display("FAIL credit_drain got next tag %0d exp 7", exp_tag); end
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL credit_empty got %b exp 0", res_valid); end
   endtask

   task automatic test_err_reserved();
      drive(2'b11, 32'h1, 32'h1, 6'd3);
      step();
      req_valid = 1'b0;
      checks++; if ({feq_en, flt_en} !== 2'b00) begin errors++; $display("FAIL rsv_enables got %b exp 00", {feq_en, flt_en}); end
      step();
      step();
      checks++; if ({res_valid, res_data, res_tag} !== {1'b1, 32'd0, 6'd3}) begin errors++; $display("FAIL rsv_result got v%b d%h t%0d exp v1 d0 t3", res_valid, res_data, res_tag); end
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL rsv_err got %b exp 1", err); end
      repeat (3) step();
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL rsv_err_sticky got %b exp 1", err); end
   endtask

   task automatic test_err_stray();
      pulse_reset();
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL stray_err_cleared got %b exp 0", err); end
      force_feq = 1'b1;
      step();
      force_feq = 1'b0;
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL stray_err got %b exp 1", err); end
      pulse_reset();
   endtask

   task automatic test_reset_inflight();
      res_ready = 1'b0;
      drive(2'b00, 32'h4000_0000, 32'h4000_0000, 6'd11);
      step();
      req_tag = 6'd12;
      step();
      req_tag = 6'd13;
      step();
      req_valid = 1'b0;
      checks++; if ({res_valid, feq_en} !== 2'b11) begin errors++; $display("FAIL inflight_busy got %b exp 11", {res_valid, feq_en}); end
      rstn = 1'b0;
      #1;
      checks++; if ({res_valid, feq_en, flt_en, err, req_ready} !== 5'b00001) begin errors++; $display("FAIL inflight_reset_ctl got %b exp 00001", {res_valid, feq_en, flt_en, err, req_ready}); end
      checks++; if ({cmp_a, cmp_b, res_data, res_tag} !== 102'h0) begin errors++; $display("FAIL inflight_reset_data got %h exp 0", {cmp_a, cmp_b, res_data, res_tag}); end
      #1;
      rstn = 1'b1;
      res_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         step();
         checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL inflight_stale got %b exp 0 at cycle %0d", res_valid, c); end
      end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL inflight_err got %b exp 0", err); end
   endtask

`ifdef FPU_CMP_FLUSH_EN
   task automatic test_flush();
      res_ready = 1'b1;
      drive(2'b00, 32'h4000_0000, 32'h4000_0000, 6'd20);
      step();
      drive(2'b10, 32'h4000_0000, 32'h4000_0000, 6'd21);
      step();
      flush = 1'b1;
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL flush_req_ready got %b exp 0", req_ready); end
      step();
      flush = 1'b0;
      req_valid = 1'b0;
      for (int c = 0; c < 5; c++) begin
         checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL flush_result got %b exp 0 at cycle %0d", res_valid, c); end
         step();
      end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL flush_err got %b exp 0", err); end
   endtask
`endif

   initial begin
      rstn      = 1'b0;
      req_valid = 1'b0;
      req_op    = 2'b00;
      req_a     = '0;
      req_b     = '0;
      req_tag   = '0;
      res_ready = 1'b1;
      force_feq = 1'b0;
`ifdef FPU_CMP_FLUSH_EN
      flush     = 1'b0;
`endif
      test_reset();
      test_feq();
      test_back_to_back_flt();
      test_fle();
      test_credits();
      test_err_reserved();
      test_err_stray();
      test_reset_inflight();
`ifdef FPU_CMP_FLUSH_EN
      test_flush();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout got running exp finished");
      $fatal(1, "timeout");
   end

endmodule
